// File: rtl/bp_pkg.sv
// Shared branch-predictor types and helpers: saturating counter arithmetic,
// 2-bit counter state names and the BTB entry layout.
package bp_pkg;

   // Widest legal configuration; narrower instances zero-extend into these fields.
   localparam int MAX_XLEN = 64;
   localparam int MAX_CTR  = 4;
   localparam int PC_STEP  = 4;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   typedef struct packed {
      logic                valid;
      logic [MAX_XLEN-1:0] tag;
      logic [MAX_XLEN-1:0] target;
      logic [MAX_CTR-1:0]  ctr;
   } btb_entry_t;

   function automatic logic [MAX_CTR-1:0] sat_inc(input logic [MAX_CTR-1:0] c, input int bits);
      logic [MAX_CTR-1:0] cap;
      cap = MAX_CTR'((1 << bits) - 1);
      return (c >= cap) ? c : c + 1'b1;
   endfunction

   function automatic logic [MAX_CTR-1:0] sat_dec(input logic [MAX_CTR-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-side lookup, execute-side update and flush bundle of the BTB.
interface btb_predictor_if #(
   parameter int XLEN = 32
);
   logic            lookup_valid;
   logic [XLEN-1:0] lookup_pc;
   logic            pred_valid;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_taken;
   logic [XLEN-1:0] upd_target;
   logic            flush;

   modport master (
      output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
      input  pred_valid, pred_taken, pred_target
   );

   modport slave (
      input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
      output pred_valid, pred_taken, pred_target
   );
endinterface

// File: rtl/btb_array.sv
// BTB storage: registered lookup read port plus a read-modify-write update port.
// A same-cycle lookup reads the pre-write contents; flush beats any write.
module btb_array
   import bp_pkg::*;
#(
   parameter int                 ENTRIES = 16,
   parameter int                 IDX_W   = $clog2(ENTRIES),
   parameter logic [MAX_CTR-1:0] CTR_RST = MAX_CTR'(2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output btb_entry_t       rd_entry,
   input  logic [IDX_W-1:0] wr_idx,
   output btb_entry_t       wr_cur,
   input  logic             wr_en,
   input  btb_entry_t       wr_entry,
   input  logic             flush
);

   btb_entry_t mem [ENTRIES];

   assign wr_cur = mem[wr_idx];

   // NOTE: the whole array is in the async reset because reset must leave
   // every counter at its allocation value, not just clear the valid bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RST};
         end
         rd_entry <= '0;
      end else begin
         // NOTE: non-blocking assignments give read-before-write for free:
         // rd_entry samples mem before this edge's write lands.
         if (rd_en) rd_entry <= mem[rd_idx];
         if (flush) begin
            for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
         end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
         end
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Tagged direct-mapped BTB with saturating direction counters; one-cycle
// registered prediction, trained by resolved branches from execute.
module btb_predictor
   import bp_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ENTRIES  = 16,
   parameter int CTR_BITS = 2,
   parameter int CTR_INIT = 2 ** (CTR_BITS - 1)
) (
   input logic            clk,
   input logic            rst,
   btb_predictor_if.slave bus
);

   localparam int                 IDX_W     = $clog2(ENTRIES);
   localparam logic [MAX_CTR-1:0] CTR_ALLOC = MAX_CTR'(CTR_INIT);

   logic [IDX_W-1:0]    look_idx, upd_idx;
   logic [MAX_XLEN-1:0] look_tag, upd_tag, look_tag_q;
   logic [XLEN-1:0]     fall_thru_q;
   logic                pred_valid_q, pred_hit, upd_hit, wr_en;
   btb_entry_t          rd_entry, wr_cur, wr_entry;
   logic                unused_bits;

   assign look_idx = bus.lookup_pc[IDX_W+1:2];
   assign look_tag = MAX_XLEN'(bus.lookup_pc[XLEN-1:IDX_W+2]);
   assign upd_idx  = bus.upd_pc[IDX_W+1:2];
   assign upd_tag  = MAX_XLEN'(bus.upd_pc[XLEN-1:IDX_W+2]);

   btb_array #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W),
      .CTR_RST (CTR_ALLOC)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (bus.lookup_valid),
      .rd_idx   (look_idx),
      .rd_entry (rd_entry),
      .wr_idx   (upd_idx),
      .wr_cur   (wr_cur),
      .wr_en    (wr_en),
      .wr_entry (wr_entry),
      .flush    (bus.flush)
   );

   // Tag and fall-through are captured alongside the array read so the
   // prediction holds while no new lookup arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred_valid_q <= 1'b0;
         look_tag_q   <= '0;
         fall_thru_q  <= '0;
      end else begin
         pred_valid_q <= bus.lookup_valid;
         if (bus.lookup_valid) begin
            look_tag_q  <= look_tag;
            fall_thru_q <= bus.lookup_pc + XLEN'(PC_STEP);
         end
      end
   end

   assign pred_hit        = rd_entry.valid && (rd_entry.tag == look_tag_q);
   assign bus.pred_valid  = pred_valid_q;
   assign bus.pred_taken  = pred_hit && rd_entry.ctr[CTR_BITS-1];
   assign bus.pred_target = bus.pred_taken ? XLEN'(rd_entry.target) : fall_thru_q;

   assign upd_hit = wr_cur.valid && (wr_cur.tag == upd_tag);

   // NOTE: defaults first so every path assigns every output -- no latches.
   always_comb begin
      wr_entry = wr_cur;
      wr_en    = 1'b0;
      if (bus.upd_valid && !bus.flush) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            if (bus.upd_taken) begin
               wr_entry.ctr    = sat_inc(wr_cur.ctr, CTR_BITS);
               wr_entry.target = MAX_XLEN'(bus.upd_target);
            end else begin
               wr_entry.ctr = sat_dec(wr_cur.ctr);
            end
         end else if (bus.upd_taken) begin
            wr_en    = 1'b1;
            wr_entry = '{valid: 1'b1, tag: upd_tag,
                         target: MAX_XLEN'(bus.upd_target), ctr: CTR_ALLOC};
         end
      end
   end

   // Byte-offset PC bits and the zero-extension headroom of the entry are
   // deliberately ignored.
   assign unused_bits = ^{bus.upd_pc[1:0], rd_entry.target, rd_entry.ctr};

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised, tagged, direct-mapped branch target buffer with per-entry saturating direction counters. Sits beside fetch: it takes the fetch PC, returns a registered taken/not-taken prediction and next-PC target one cycle later, and is trained by the resolved-branch update from execute. It supersedes the untagged 16-entry always-taken-on-hit predictor with configurable depth, width and hysteresis, explicit flush, and defined read/write ordering.

## Interface
- `XLEN`, 32, address/target width; must be at least `IDX_W+3`.
- `ENTRIES`, 16, BTB depth; power of two, 2 to 1024. `IDX_W = log2(ENTRIES)`.
- `CTR_BITS`, 2, direction counter width, 1 to 4.
- `CTR_INIT`, `2**(CTR_BITS-1)`, counter value written on allocation (weakly taken).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `lookup_valid`  in  1  the fetch PC is valid this cycle.
- `lookup_pc`  in  XLEN  branch instruction address.
- `pred_valid`  out  1  the prediction outputs are valid this cycle.
- `pred_taken`  out  1  predicted direction.
- `pred_target`  out  XLEN  predicted next PC.
- `upd_valid`  in  1  a resolved branch is presented this cycle.
- `upd_pc`  in  XLEN  address of the resolved branch.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  XLEN  actual taken target.
- `flush`  in  1  synchronous invalidate of all entries.

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[XLEN-1:IDX_W+2]`. `pc[1:0]` is ignored.
- Each entry holds a valid bit, a tag, a target (XLEN bits) and a `CTR_BITS` counter.
- A lookup hits when the indexed entry is valid and its tag equals the lookup tag.
- Prediction:
  - `pred_taken` = hit AND counter MSB.
  - `pred_target` = the entry target when `pred_taken` is 1; otherwise `lookup_pc + 4`, truncated to XLEN so it wraps.
- Update on a hit:
  - Counter saturates: it increments when `upd_taken` is 1 (capped at all-ones) and decrements when it is 0 (floored at 0).
  - When `upd_taken` is 1, the target is overwritten with `upd_target`.
- Update on a miss:
  - When `upd_taken` is 1, the entry is allocated or replaced: valid=1, new tag, `upd_target`, counter=`CTR_INIT`.
  - When `upd_taken` is 0, nothing changes.
- `flush` clears every valid bit. Targets, tags and counters are left as they are.

## Timing
- Lookup latency is 1 cycle. `lookup_valid` in cycle N gives `pred_*` in cycle N+1.
  - When `lookup_valid`=0, `pred_valid` is 0 in N+1 and `pred_taken`/`pred_target` hold their previous values.
- An update presented in cycle N is written at the end of N. A lookup in N+1 sees it.
- Lookup and update in the same cycle, same index: read-before-write. The prediction uses pre-update state and there is no bypass.
- `flush` together with `upd_valid` in the same cycle: flush wins and the update is discarded. A lookup in that cycle sees pre-flush state.
- Reset, asynchronous, any time including mid-update:
  - All valid bits 0, counters = `CTR_INIT`, tags and targets 0.
  - `pred_valid`=0, `pred_taken`=0, `pred_target`=0.
  - No update in flight survives reset.
- No backpressure. Every lookup and every update is accepted in its cycle.

## Structure
- Shared package `bp_pkg`:
  - `sat_inc`/`sat_dec` functions.
  - Localparams for the 2-bit counter states SNT=0, WNT=1, WT=2, ST=3.
  - The entry struct type: valid, tag, target, ctr.
  - The `PC_STEP`=4 constant.
- Sub-module `btb_array`: storage with one registered read port and one write port, read-before-write.
- Top level: hit and direction logic, fall-through adder, update/allocate control, flush.

## Test plan
- Reset, then look up 0x100 → next cycle `pred_valid`=1, `pred_taken`=0, `pred_target`=0x104.
- Update pc=0x100, taken, target 0x200; then look up 0x100 → `pred_taken`=1, `pred_target`=0x200. Look up 0x140 (same index, different tag) → `pred_taken`=0, `pred_target`=0x144.
- Hysteresis with `CTR_BITS`=2, starting from that allocation (ctr=2):
  - One not-taken update: ctr=1, predicts not taken, target 0x104.
  - Two taken updates: ctr=3.
  - One not-taken update: ctr=2, still predicts taken at 0x200.
  - Five further not-taken updates: ctr stays at 0.
- Same-cycle lookup and taken-allocate at 0x180: the prediction returned is not taken. A lookup in the following cycle returns taken.
- `flush` with a taken update at 0x300 in the same cycle → a later lookup of 0x300 is not taken, and earlier entries are also invalid.
- Look up 0xFFFF_FFFC on a miss → `pred_target`=0x0000_0000. Assert `rst` low mid-update → outputs go to 0 immediately, and after release a lookup of 0x100 is not taken.
